// File: rtl/elevator_pkg.sv
// Shared types and helpers for the hall-call dispatcher: FSM encoding,
// floor-field width derivation and unsigned floor distance.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_OFFER  = 2'd2
  } state_t;

  function automatic int unsigned floor_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ELEV_NUM_FLOORS = 16;
  localparam int unsigned ELEV_FW         = floor_width(ELEV_NUM_FLOORS);

  // Distance without wrap: floors are linear, never modular.
  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/min_heap.sv
// Combinational argmin over a set of valid entries; on equal values the
// lowest index wins.
module min_heap #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned HEAP_DEPTH = 4,
  localparam int unsigned IDX_W = (HEAP_DEPTH > 1) ? $clog2(HEAP_DEPTH) : 1
) (
  input  logic [HEAP_DEPTH-1:0]            valid,
  input  logic [DATA_WIDTH*HEAP_DEPTH-1:0] data_in,
  output logic [IDX_W-1:0]                 min_index_out,
  output logic                             min_valid_out
);

  logic [DATA_WIDTH-1:0] w_best;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_found;

  // Ascending scan with strict less-than keeps the lower index on ties.
  always_comb begin
    w_best  = '1;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < HEAP_DEPTH; i++) begin
      if (valid[i] && (!w_found || (data_in[DATA_WIDTH*i +: DATA_WIDTH] < w_best))) begin
        w_best  = data_in[DATA_WIDTH*i +: DATA_WIDTH];
        w_idx   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign min_index_out = w_idx;
  assign min_valid_out = w_found;

endmodule

// File: rtl/elevator_dispatcher.sv
// Hall-call dispatcher: buffers floor requests in a duplicate-filtering FIFO
// and offers the head to the nearest ready car over a valid/ready port.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 16,
  parameter int unsigned NUM_CARS    = 4,
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned FW   = floor_width(NUM_FLOORS),
  localparam int unsigned CW   = $clog2(NUM_CARS),
  localparam int unsigned PW   = $clog2(MAX_PENDING),
  localparam int unsigned CNTW = PW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [FW-1:0]          req_floor,
  output logic                   req_ready,
  output logic                   req_dropped,
  input  logic [FW*NUM_CARS-1:0] car_floor,
  input  logic [NUM_CARS-1:0]    car_ready,
  output logic [NUM_CARS-1:0]    car_valid,
  output logic [FW-1:0]          car_target,
  output logic [CNTW-1:0]        pending_count
);

  logic [FW-1:0]          r_fifo_floor [MAX_PENDING];
  logic [MAX_PENDING-1:0] r_fifo_vld;
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [CNTW-1:0]        r_count;
  state_t                 r_state;
  logic [NUM_CARS-1:0]    r_car_valid;
  logic [FW-1:0]          r_car_target;
  logic                   r_dropped;

  state_t                 w_state_nxt;
  logic [CNTW-1:0]        w_count_nxt;
  logic                   w_push_hs;
  logic                   w_dup;
  logic                   w_oob;
  logic                   w_store;
  logic                   w_pop;
  logic                   w_offer_load;
  logic [FW-1:0]          w_head_floor;
  logic [FW*NUM_CARS-1:0] w_dist;
  logic [CW-1:0]          w_min_idx;
  logic                   w_min_valid;

  assign req_ready     = (r_count != CNTW'(MAX_PENDING));
  assign w_push_hs     = req_valid & req_ready;
  assign w_head_floor  = r_fifo_floor[r_head];
  assign w_oob         = (32'(req_floor) >= NUM_FLOORS);
  assign w_store       = w_push_hs & ~w_dup & ~w_oob;
  assign w_pop         = (r_state == ST_OFFER) && (|(r_car_valid & car_ready));
  assign w_count_nxt   = r_count + CNTW'(w_store) - CNTW'(w_pop);

  // The head stays valid until its pop edge, so a same-cycle repeat still drops.
  always_comb begin
    w_dup = 1'b0;
    for (int unsigned i = 0; i < MAX_PENDING; i++) begin
      if (r_fifo_vld[i] && (r_fifo_floor[i] == req_floor)) begin
        w_dup = 1'b1;
      end
    end
  end

  always_comb begin
    w_dist = '0;
    for (int unsigned i = 0; i < NUM_CARS; i++) begin
      w_dist[FW*i +: FW] = FW'(abs_diff(32'(car_floor[FW*i +: FW]), 32'(w_head_floor)));
    end
  end

  min_heap #(
    .DATA_WIDTH (FW),
    .HEAP_DEPTH (NUM_CARS)
  ) u_argmin (
    .valid         (car_ready),
    .data_in       (w_dist),
    .min_index_out (w_min_idx),
    .min_valid_out (w_min_valid)
  );

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_fifo_floor[r_tail] <= req_floor;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_vld <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_store) begin
        r_fifo_vld[r_tail] <= 1'b1;
        r_tail             <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_fifo_vld[r_head] <= 1'b0;
        r_head             <= r_head + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_offer_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (w_min_valid) begin
          w_offer_load = 1'b1;
          w_state_nxt  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (w_pop) begin
          w_state_nxt = (w_count_nxt != '0) ? ST_SELECT : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_car_valid  <= '0;
      r_car_target <= '0;
    end else if (w_offer_load) begin
      r_car_valid  <= NUM_CARS'(1) << w_min_idx;
      r_car_target <= w_head_floor;
    end else if (w_pop) begin
      r_car_valid  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_push_hs & (w_dup | w_oob);
    end
  end

  assign req_dropped   = r_dropped;
  assign car_valid     = r_car_valid;
  assign car_target    = r_car_target;
  assign pending_count = r_count;

endmodule
